// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared I2S constants: default word/slot sizes and channel codes.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int   c_BITS_PRECISION = 24;
    localparam int   c_SLOT_BITS      = 32;
    localparam logic c_LEFT           = 1'b1;
    localparam logic c_RIGHT          = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2sout_if.sv
`default_nettype none
// ============================================================================
// Module      : i2sout_if
// Description : Sample stream from the system into the I2S transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2sout_if
    import i2s_pkg::*;
#(
    parameter int BITS_PRECISION = c_BITS_PRECISION
) ();

    logic [BITS_PRECISION-1:0] data_out;
    logic                      data_left_rightn;
    logic                      data_valid;
    logic                      data_ready;

    modport master (
        output data_out,
        output data_left_rightn,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_left_rightn,
        input  data_valid,
        output data_ready
    );

endinterface
`default_nettype wire

// File: rtl/i2sout.sv
`default_nettype none
// ============================================================================
// Module      : i2sout
// Description : I2S transmitter, one-bit delay, MSB first, one buffer per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module i2sout
    import i2s_pkg::*;
#(
    parameter int BITS_PRECISION = c_BITS_PRECISION,
    parameter int SLOT_BITS      = c_SLOT_BITS
) (
    input  wire logic sck,
    input  wire logic rst,
    i2sout_if.slave   bus,
    output logic      ws,
    output logic      sd,
    output logic      underrun,
    output logic      sync_error
);

    localparam int                 c_CNT_W    = cnt_width(SLOT_BITS);
    localparam int                 c_MSB      = BITS_PRECISION - 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SLOT_BITS - 1);
    localparam logic [31:0]        c_BITS_U   = 32'(BITS_PRECISION);
    localparam bit                 c_TIGHT    = (SLOT_BITS == BITS_PRECISION);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ws;
    logic               r_sd;
    logic               r_underrun;
    logic               r_sync_error;
    logic               r_ready;
    logic [c_MSB:0]     r_shift;
    logic [c_MSB:0]     r_buf_l;
    logic [c_MSB:0]     r_buf_r;
    logic               r_full_l;
    logic               r_full_r;
    logic               r_expect;

    logic               w_wrap;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_new_left;
    logic               w_accept;
    logic               w_tag_ok;
    logic               w_store;
    logic               w_full_l_nxt;
    logic               w_full_r_nxt;
    logic               w_expect_nxt;
    logic               w_ready_nxt;
    logic               w_latch_full;
    logic [c_MSB:0]     w_latch_word;
    logic               w_sd_nxt;

    assign w_wrap     = (r_cnt == c_CNT_LAST);
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + c_CNT_W'(1);
    assign w_new_left = ~r_ws;
    assign w_accept   = bus.data_valid & r_ready;
    assign w_tag_ok   = (bus.data_left_rightn == r_expect);
    assign w_store    = w_accept & w_tag_ok;

    always_comb begin
        w_full_l_nxt = r_full_l;
        w_full_r_nxt = r_full_r;
        // Latch empties first so a same-edge accept lands in the next slot.
        if (w_wrap) begin
            if (w_new_left) w_full_l_nxt = 1'b0;
            else            w_full_r_nxt = 1'b0;
        end
        if (w_store) begin
            if (r_expect == c_LEFT) w_full_l_nxt = 1'b1;
            else                    w_full_r_nxt = 1'b1;
        end
        w_expect_nxt = w_store ? ~r_expect : r_expect;
        w_ready_nxt  = (w_expect_nxt == c_LEFT) ? ~w_full_l_nxt : ~w_full_r_nxt;

        w_latch_full = w_new_left ? r_full_l : r_full_r;
        w_latch_word = '0;
        if (w_latch_full) w_latch_word = w_new_left ? r_buf_l : r_buf_r;

        // With a full-width slot the last data bit spills into cnt 0.
        w_sd_nxt = 1'b0;
        if (w_wrap)                           w_sd_nxt = c_TIGHT ? r_shift[c_MSB] : 1'b0;
        else if (32'(w_cnt_nxt) <= c_BITS_U)  w_sd_nxt = r_shift[c_MSB];
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_cnt        <= c_CNT_LAST;
            r_ws         <= 1'b0;
            r_sd         <= 1'b0;
            r_shift      <= '0;
            r_buf_l      <= '0;
            r_buf_r      <= '0;
            r_full_l     <= 1'b0;
            r_full_r     <= 1'b0;
            r_expect     <= c_LEFT;
            r_ready      <= 1'b1;
            r_underrun   <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_sd         <= w_sd_nxt;
            r_underrun   <= w_wrap & ~w_latch_full;
            r_sync_error <= w_accept & ~w_tag_ok;
            r_full_l     <= w_full_l_nxt;
            r_full_r     <= w_full_r_nxt;
            r_expect     <= w_expect_nxt;
            r_ready      <= w_ready_nxt;
            if (w_wrap) begin
                r_ws    <= ~r_ws;
                r_shift <= w_latch_word;
            end else begin
                r_shift <= r_shift << 1;
            end
            if (w_store && r_expect == c_LEFT) r_buf_l <= bus.data_out;
            if (w_store && r_expect != c_LEFT) r_buf_r <= bus.data_out;
        end
    end

    assign ws             = r_ws;
    assign sd             = r_sd;
    assign underrun       = r_underrun;
    assign sync_error     = r_sync_error;
    assign bus.data_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_i2sout.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2sout
// Description : Random-stimulus bench for i2sout, 32-bit and 24-bit slot lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2sout;
    import i2s_pkg::*;

    localparam int c_B = 24;

    logic sck = 1'b0;
    logic rst = 1'b1;
    always #5 sck = ~sck;

    i2sout_if #(.BITS_PRECISION(c_B)) bus0 ();
    i2sout_if #(.BITS_PRECISION(c_B)) bus1 ();

    logic ws0, sd0, un0, se0;
    logic ws1, sd1, un1, se1;

    i2sout #(.BITS_PRECISION(c_B), .SLOT_BITS(32)) u_dut0 (
        .sck(sck), .rst(rst), .bus(bus0),
        .ws(ws0), .sd(sd0), .underrun(un0), .sync_error(se0)
    );

    i2sout #(.BITS_PRECISION(c_B), .SLOT_BITS(24)) u_dut1 (
        .sck(sck), .rst(rst), .bus(bus1),
        .ws(ws1), .sd(sd1), .underrun(un1), .sync_error(se1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          slot_len [2];
    int          m_n      [2];
    bit          m_exp    [2];
    bit          m_pv     [2][2];
    logic [23:0] m_pw     [2][2];
    logic [23:0] m_word   [2];
    logic [23:0] m_prev   [2];
    bit          m_under  [2];
    bit          m_sync   [2];
    bit          m_ready  [2];
    int          acc_cnt  [2];

    bit          d_v      [2];
    bit          d_tag    [2];
    logic [23:0] d_data   [2];
    logic [23:0] dir_w    [2][2];

    int p_valid     = 0;
    bit p_bad       = 0;
    bit directed_en = 0;
    bit bad_first   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_n[l] = -1; m_exp[l] = c_LEFT; m_word[l] = '0; m_prev[l] = '0;
            m_under[l] = 0; m_sync[l] = 0; m_ready[l] = 1; acc_cnt[l] = 0;
            for (int c = 0; c < 2; c++) begin
                m_pv[l][c] = 0; m_pw[l][c] = '0;
            end
        end
    endtask

    // Slot k carries the oldest sample of its channel accepted before the slot began.
    task automatic model_edge(input int l);
        int pos, slot;
        bit ch, acc;
        m_n[l]++;
        pos  = m_n[l] % slot_len[l];
        slot = m_n[l] / slot_len[l];
        ch   = (slot % 2 == 0);
        acc  = d_v[l] && m_ready[l];
        m_under[l] = 0;
        m_sync[l]  = 0;
        if (pos == 0) begin
            m_prev[l] = m_word[l];
            if (m_pv[l][ch]) begin
                m_word[l] = m_pw[l][ch];
                m_pv[l][ch] = 0;
            end else begin
                m_word[l] = '0;
                m_under[l] = 1;
            end
        end
        if (acc) begin
            if (d_tag[l] == m_exp[l]) begin
                m_pw[l][m_exp[l]] = d_data[l];
                m_pv[l][m_exp[l]] = 1;
                m_exp[l] = !m_exp[l];
                acc_cnt[l]++;
            end else begin
                m_sync[l] = 1;
            end
        end
        m_ready[l] = !m_pv[l][m_exp[l]];
    endtask

    task automatic check_lane(input int l, input logic ws, input logic sd,
                              input logic rdy, input logic un, input logic se);
        int pos, slot;
        bit sd_e;
        pos  = m_n[l] % slot_len[l];
        slot = m_n[l] / slot_len[l];
        sd_e = 0;
        if (pos >= 1 && pos <= c_B)           sd_e = m_word[l][c_B - pos];
        else if (pos == 0 && slot_len[l] == c_B) sd_e = m_prev[l][0];
        check_eq($sformatf("L%0d ws", l),         ws,  (slot % 2 == 0));
        check_eq($sformatf("L%0d sd pos%0d", l, pos), sd, sd_e);
        check_eq($sformatf("L%0d ready", l),      rdy, m_ready[l]);
        check_eq($sformatf("L%0d underrun", l),   un,  m_under[l]);
        check_eq($sformatf("L%0d sync_error", l), se,  m_sync[l]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " ws0"}, ws0, 0);
        check_eq({tag, " sd0"}, sd0, 0);
        check_eq({tag, " rdy0"}, bus0.data_ready, 1);
        check_eq({tag, " un0"}, un0, 0);
        check_eq({tag, " se0"}, se0, 0);
        check_eq({tag, " ws1"}, ws1, 0);
        check_eq({tag, " sd1"}, sd1, 0);
        check_eq({tag, " rdy1"}, bus1.data_ready, 1);
        check_eq({tag, " un1"}, un1, 0);
        check_eq({tag, " se1"}, se1, 0);
    endtask

    task automatic choose(input int l);
        d_v[l]    = ($urandom_range(99) < p_valid);
        d_tag[l]  = m_exp[l];
        if (p_bad && $urandom_range(7) == 0) d_tag[l] = !d_tag[l];
        d_data[l] = 24'($urandom);
        if (directed_en && acc_cnt[l] < 2) begin
            d_v[l]    = 1;
            d_tag[l]  = m_exp[l];
            d_data[l] = dir_w[l][acc_cnt[l]];
        end
        if (bad_first && l == 0) begin
            d_v[l]    = 1;
            d_tag[l]  = c_RIGHT;
            bad_first = 0;
        end
    endtask

    task automatic drive();
        bus0.data_valid       = d_v[0];
        bus0.data_left_rightn = d_tag[0];
        bus0.data_out         = d_data[0];
        bus1.data_valid       = d_v[1];
        bus1.data_left_rightn = d_tag[1];
        bus1.data_out         = d_data[1];
    endtask

    task automatic clear_inputs();
        for (int l = 0; l < 2; l++) begin
            d_v[l] = 0; d_tag[l] = 0; d_data[l] = '0;
        end
        drive();
    endtask

    task automatic run_cycle();
        @(negedge sck);
        choose(0);
        choose(1);
        drive();
        @(posedge sck);
        model_edge(0);
        model_edge(1);
        #1;
        check_lane(0, ws0, sd0, bus0.data_ready, un0, se0);
        check_lane(1, ws1, sd1, bus1.data_ready, un1, se1);
    endtask

    initial begin
        bit aligned;
        slot_len[0] = 32;
        slot_len[1] = 24;
        dir_w[0][0] = 24'hA5A5A5; dir_w[0][1] = 24'h5A5A5A;
        dir_w[1][0] = 24'h800001; dir_w[1][1] = 24'h000001;
        model_reset();
        clear_inputs();

        rst = 1'b1;
        repeat (3) @(posedge sck);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed words first, then random traffic.
        directed_en = 1; p_valid = 85; p_bad = 0;
        repeat (1500) run_cycle();
        directed_en = 0;

        p_bad = 1;
        repeat (1500) run_cycle();

        // Starved: every slot underruns.
        p_valid = 0; p_bad = 0;
        repeat (200) run_cycle();

        // Reset mid-way through a left slot of the 32-bit lane.
        p_valid = 90;
        aligned = 0;
        for (int i = 0; i < 200 && !aligned; i++) begin
            run_cycle();
            aligned = (m_n[0] % 32 == 10) && ((m_n[0] / 32) % 2 == 0);
        end
        check_eq("rst_align_reached", aligned, 1);
        clear_inputs();
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midslot_rst");
        model_reset();
        rst = 1'b0;

        bad_first = 1; p_valid = 80; p_bad = 1;
        repeat (1500) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
